// File: rtl/coherence_line_controller.sv
// Direct-mapped MSI/MESI snooping cache controller: one CPU port, one bus emitter,
// always-on snoop port and dirty-victim writeback.
module coherence_line_controller #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LINES  = 4,
    parameter int MESI   = 0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 cpu_valid,
    output logic                 cpu_ready,
    input  logic                 cpu_write,
    input  logic [ADDR_W-1:0]    cpu_addr,
    input  logic [DATA_W-1:0]    cpu_wdata,
    output logic                 cpu_done,
    output logic [DATA_W-1:0]    cpu_rdata,
    output logic                 bus_req,
    input  logic                 bus_gnt,
    output logic [5:0]           bus_cmd,
    output logic [ADDR_W-1:0]    bus_addr,
    output logic [DATA_W-1:0]    bus_data,
    input  logic                 snoop_valid,
    input  logic [5:0]           snoop_cmd,
    input  logic [ADDR_W-1:0]    snoop_addr,
    output logic                 snoop_flush,
    output logic [DATA_W-1:0]    snoop_flush_data,
    input  logic                 resp_valid,
    input  logic [DATA_W-1:0]    resp_data,
    input  logic                 resp_shared,
    output logic [2*LINES-1:0]   state_vec
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W;

    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_S = 2'b01;
    localparam logic [1:0] ST_M = 2'b10;
    localparam logic [1:0] ST_E = 2'b11;

    localparam logic [5:0] CMD_WMISS = 6'b000000;
    localparam logic [5:0] CMD_RMISS = 6'b000001;
    localparam logic [5:0] CMD_WB    = 6'b000010;
    localparam logic [5:0] CMD_INV   = 6'b000100;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, WB_REQ, MISS_REQ, UPG_REQ, WAIT_RESP
    } fsm_t;

    fsm_t               fsm_q, fsm_d;
    logic               req_write_q, req_write_d;
    logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
    logic [DATA_W-1:0]  req_wdata_q, req_wdata_d;
    logic               snoop_flush_q, snoop_flush_d;
    logic [DATA_W-1:0]  snoop_flush_data_q, snoop_flush_data_d;

    logic [TAG_W-1:0]   tag_q [LINES];
    logic [TAG_W-1:0]   tag_d [LINES];
    logic [DATA_W-1:0]  data_q [LINES];
    logic [DATA_W-1:0]  data_d [LINES];
    logic [1:0]         st_q [LINES];
    logic [1:0]         st_d [LINES];
    logic [1:0]         st_eff [LINES];

    logic [IDX_W-1:0]   s_idx, r_idx;
    logic [TAG_W-1:0]   s_tag, r_tag;
    logic               q_hit, eff_hit;

    assign s_idx = snoop_addr[IDX_W-1:0];
    assign s_tag = snoop_addr[ADDR_W-1:IDX_W];
    assign r_idx = req_addr_q[IDX_W-1:0];
    assign r_tag = req_addr_q[ADDR_W-1:IDX_W];

    // st_eff is each line's state after this cycle's snoop; local updates build on it.
    for (genvar gi = 0; gi < LINES; gi++) begin : g_line
        always_comb begin
            st_eff[gi] = st_q[gi];
            if (snoop_valid && s_idx == IDX_W'(gi) && tag_q[gi] == s_tag && st_q[gi] != ST_I) begin
                case (snoop_cmd)
                    CMD_RMISS: if (st_q[gi] == ST_M || st_q[gi] == ST_E) st_eff[gi] = ST_S;
                    CMD_WMISS: st_eff[gi] = ST_I;
                    CMD_INV:   if (st_q[gi] != ST_M) st_eff[gi] = ST_I;
                    default:   st_eff[gi] = st_q[gi];
                endcase
            end
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                tag_q[gi]  <= '0;
                data_q[gi] <= '0;
                st_q[gi]   <= ST_I;
            end else begin
                tag_q[gi]  <= tag_d[gi];
                data_q[gi] <= data_d[gi];
                st_q[gi]   <= st_d[gi];
            end
        end

        assign state_vec[2*gi +: 2] = st_q[gi];
    end

    always_comb begin
        snoop_flush_d      = 1'b0;
        snoop_flush_data_d = '0;
        if (snoop_valid && tag_q[s_idx] == s_tag && st_q[s_idx] == ST_M &&
            (snoop_cmd == CMD_RMISS || snoop_cmd == CMD_WMISS)) begin
            snoop_flush_d      = 1'b1;
            snoop_flush_data_d = data_q[s_idx];
        end
    end

    assign q_hit   = (tag_q[r_idx] == r_tag) && (st_q[r_idx] != ST_I);
    assign eff_hit = (tag_q[r_idx] == r_tag) && (st_eff[r_idx] != ST_I);

    // Bus outputs decode only registered state, so they hold steady until granted.
    always_comb begin
        bus_req  = 1'b0;
        bus_cmd  = CMD_WMISS;
        bus_addr = '0;
        bus_data = '0;
        case (fsm_q)
            WB_REQ: if (st_q[r_idx] == ST_M) begin
                bus_req  = 1'b1;
                bus_cmd  = CMD_WB;
                bus_addr = {tag_q[r_idx], r_idx};
                bus_data = data_q[r_idx];
            end
            MISS_REQ: begin
                bus_req  = 1'b1;
                bus_cmd  = req_write_q ? CMD_WMISS : CMD_RMISS;
                bus_addr = req_addr_q;
            end
            UPG_REQ: if (q_hit) begin
                bus_req  = 1'b1;
                bus_cmd  = CMD_INV;
                bus_addr = req_addr_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        fsm_d       = fsm_q;
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        tag_d       = tag_q;
        data_d      = data_q;
        st_d        = st_eff;
        cpu_done    = 1'b0;
        cpu_rdata   = '0;
        case (fsm_q)
            IDLE: if (cpu_valid) begin
                req_write_d = cpu_write;
                req_addr_d  = cpu_addr;
                req_wdata_d = cpu_wdata;
                fsm_d       = LOOKUP;
            end
            LOOKUP: begin
                if (eff_hit && !req_write_q) begin
                    cpu_done  = 1'b1;
                    cpu_rdata = data_q[r_idx];
                    fsm_d     = IDLE;
                end else if (eff_hit && st_eff[r_idx] == ST_S) begin
                    fsm_d = UPG_REQ;
                end else if (eff_hit) begin
                    st_d[r_idx]   = ST_M;
                    data_d[r_idx] = req_wdata_q;
                    cpu_done      = 1'b1;
                    fsm_d         = IDLE;
                end else begin
                    fsm_d = (st_eff[r_idx] == ST_M) ? WB_REQ : MISS_REQ;
                end
            end
            WB_REQ: begin
                // A victim already flushed/invalidated by a snoop needs no writeback.
                if (st_q[r_idx] != ST_M) begin
                    fsm_d = MISS_REQ;
                end else if (bus_gnt) begin
                    st_d[r_idx] = ST_I;
                    fsm_d       = MISS_REQ;
                end
            end
            MISS_REQ: if (bus_gnt) fsm_d = WAIT_RESP;
            UPG_REQ: begin
                if (!q_hit) begin
                    fsm_d = MISS_REQ;
                end else if (bus_gnt) begin
                    if (eff_hit) begin
                        st_d[r_idx]   = ST_M;
                        data_d[r_idx] = req_wdata_q;
                        cpu_done      = 1'b1;
                        fsm_d         = IDLE;
                    end else begin
                        fsm_d = MISS_REQ;
                    end
                end
            end
            WAIT_RESP: if (resp_valid) begin
                tag_d[r_idx] = r_tag;
                cpu_done     = 1'b1;
                fsm_d        = IDLE;
                if (req_write_q) begin
                    data_d[r_idx] = req_wdata_q;
                    st_d[r_idx]   = ST_M;
                end else begin
                    data_d[r_idx] = resp_data;
                    st_d[r_idx]   = ((MESI != 0) && !resp_shared) ? ST_E : ST_S;
                    cpu_rdata     = resp_data;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q              <= IDLE;
            req_write_q        <= 1'b0;
            req_addr_q         <= '0;
            req_wdata_q        <= '0;
            snoop_flush_q      <= 1'b0;
            snoop_flush_data_q <= '0;
        end else begin
            fsm_q              <= fsm_d;
            req_write_q        <= req_write_d;
            req_addr_q         <= req_addr_d;
            req_wdata_q        <= req_wdata_d;
            snoop_flush_q      <= snoop_flush_d;
            snoop_flush_data_q <= snoop_flush_data_d;
        end
    end

    assign cpu_ready        = (fsm_q == IDLE);
    assign snoop_flush      = snoop_flush_q;
    assign snoop_flush_data = snoop_flush_data_q;

endmodule

// File: tb/tb_coherence_line_controller.sv
// Directed bench for coherence_line_controller: a MESI=0 instance is fully checked,
// a MESI=1 twin on the same stimulus checks the Exclusive fill.
module tb_coherence_line_controller;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_valid = 1'b0, cpu_write = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0;
    logic        bus_gnt = 1'b0;
    logic        snoop_valid = 1'b0;
    logic [5:0]  snoop_cmd = '0;
    logic [15:0] snoop_addr = '0;
    logic        resp_valid = 1'b0, resp_shared = 1'b0;
    logic [15:0] resp_data = '0;

    logic        cpu_ready, cpu_done, bus_req, snoop_flush;
    logic [15:0] cpu_rdata, bus_addr, bus_data, snoop_flush_data;
    logic [5:0]  bus_cmd;
    logic [7:0]  state_vec;

    logic        e_cpu_ready, e_cpu_done, e_bus_req, e_snoop_flush;
    logic [15:0] e_cpu_rdata, e_bus_addr, e_bus_data, e_snoop_flush_data;
    logic [5:0]  e_bus_cmd;
    logic [7:0]  e_state_vec;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    coherence_line_controller #(.ADDR_W(16), .DATA_W(16), .LINES(4), .MESI(0)) dut (
        .clock(clock), .reset_n(reset_n),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_write(cpu_write),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_cmd(bus_cmd), .bus_addr(bus_addr),
        .bus_data(bus_data), .snoop_valid(snoop_valid), .snoop_cmd(snoop_cmd),
        .snoop_addr(snoop_addr), .snoop_flush(snoop_flush), .snoop_flush_data(snoop_flush_data),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_shared(resp_shared),
        .state_vec(state_vec)
    );

    coherence_line_controller #(.ADDR_W(16), .DATA_W(16), .LINES(4), .MESI(1)) dut_mesi (
        .clock(clock), .reset_n(reset_n),
        .cpu_valid(cpu_valid), .cpu_ready(e_cpu_ready), .cpu_write(cpu_write),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_done(e_cpu_done), .cpu_rdata(e_cpu_rdata),
        .bus_req(e_bus_req), .bus_gnt(bus_gnt), .bus_cmd(e_bus_cmd), .bus_addr(e_bus_addr),
        .bus_data(e_bus_data), .snoop_valid(snoop_valid), .snoop_cmd(snoop_cmd),
        .snoop_addr(snoop_addr), .snoop_flush(e_snoop_flush), .snoop_flush_data(e_snoop_flush_data),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_shared(resp_shared),
        .state_vec(e_state_vec)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Leaves the bench one cycle later, sampling inside the LOOKUP cycle.
    task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d);
        cpu_valid = 1'b1; cpu_write = w; cpu_addr = a; cpu_wdata = d;
        #1;
        check("cpu_ready_idle", cpu_ready, 1);
        cyc();
        cpu_valid = 1'b0;
        #1;
        $display("TXN %s addr=0x%04h wdata=0x%04h", w ? "WR" : "RD", a, d);
    endtask

    task automatic grant();
        bus_gnt = 1'b1;
        cyc();
        bus_gnt = 1'b0;
        #1;
    endtask

    task automatic snoop(input logic [5:0] c, input logic [15:0] a);
        snoop_valid = 1'b1; snoop_cmd = c; snoop_addr = a;
        cyc();
        snoop_valid = 1'b0;
        #1;
        $display("TXN SNOOP cmd=%06b addr=0x%04h", c, a);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset
        repeat (3) cyc();
        check("rst_state_vec", state_vec, 8'h00);
        check("rst_bus_req", bus_req, 0);
        check("rst_cpu_done", cpu_done, 0);
        check("rst_snoop_flush", snoop_flush, 0);
        reset_n = 1'b1;
        cyc();
        check("rst_cpu_ready", cpu_ready, 1);

        // read miss 0x0005, unshared fill
        issue(1'b0, 16'h0005, 16'h0000);
        check("rd_miss_lookup_done", cpu_done, 0);
        check("rd_miss_lookup_ready", cpu_ready, 0);
        cyc();
        check("rd_miss_req", bus_req, 1);
        check("rd_miss_cmd", bus_cmd, 6'b000001);
        check("rd_miss_addr", bus_addr, 16'h0005);
        check("rd_miss_data", bus_data, 16'h0000);
        cyc();
        check("rd_miss_req_hold", bus_req, 1);
        check("rd_miss_addr_hold", bus_addr, 16'h0005);
        grant();
        check("rd_miss_req_drop", bus_req, 0);
        resp_valid = 1'b1; resp_data = 16'hABCD; resp_shared = 1'b0;
        #1;
        check("rd_fill_done", cpu_done, 1);
        check("rd_fill_rdata", cpu_rdata, 16'hABCD);
        cyc();
        resp_valid = 1'b0;
        #1;
        check("rd_fill_state_msi", state_vec, 8'h04);
        check("rd_fill_state_mesi", e_state_vec, 8'h0C);
        check("rd_fill_ready", cpu_ready, 1);

        // write hit in S -> upgrade
        issue(1'b1, 16'h0005, 16'h1234);
        check("upg_lookup_done", cpu_done, 0);
        cyc();
        check("upg_req", bus_req, 1);
        check("upg_cmd", bus_cmd, 6'b000100);
        check("upg_addr", bus_addr, 16'h0005);
        bus_gnt = 1'b1;
        #1;
        check("upg_gnt_done", cpu_done, 1);
        cyc();
        bus_gnt = 1'b0;
        #1;
        check("upg_state_m", state_vec, 8'h08);
        issue(1'b0, 16'h0005, 16'h0000);
        check("rd_hit_done", cpu_done, 1);
        check("rd_hit_rdata", cpu_rdata, 16'h1234);
        check("rd_hit_no_bus", bus_req, 0);
        cyc();

        // index wrap: read 0x0009 evicts dirty 0x0005
        issue(1'b0, 16'h0009, 16'h0000);
        check("wb_lookup_done", cpu_done, 0);
        cyc();
        check("wb_req", bus_req, 1);
        check("wb_cmd", bus_cmd, 6'b000010);
        check("wb_addr", bus_addr, 16'h0005);
        check("wb_data", bus_data, 16'h1234);
        grant();
        check("wb_victim_inv", state_vec, 8'h00);
        check("wb_then_miss_cmd", bus_cmd, 6'b000001);
        check("wb_then_miss_addr", bus_addr, 16'h0009);
        check("wb_then_miss_data", bus_data, 16'h0000);
        grant();
        resp_valid = 1'b1; resp_data = 16'h5555; resp_shared = 1'b1;
        #1;
        check("wrap_fill_rdata", cpu_rdata, 16'h5555);
        cyc();
        resp_valid = 1'b0;
        #1;
        check("wrap_state_s", state_vec, 8'h04);
        snoop(6'b000100, 16'h0005);
        check("snoop_tag_mismatch", state_vec, 8'h04);

        // write miss 0x0005 (victim S, no writeback), then snoops
        issue(1'b1, 16'h0005, 16'h1234);
        cyc();
        check("wr_miss_cmd", bus_cmd, 6'b000000);
        check("wr_miss_addr", bus_addr, 16'h0005);
        grant();
        resp_valid = 1'b1; resp_data = 16'hFFFF;
        #1;
        check("wr_fill_done", cpu_done, 1);
        cyc();
        resp_valid = 1'b0;
        #1;
        check("wr_fill_state_m", state_vec, 8'h08);
        snoop(6'b000001, 16'h0005);
        check("snoop_rd_flush", snoop_flush, 1);
        check("snoop_rd_flush_data", snoop_flush_data, 16'h1234);
        check("snoop_rd_state_s", state_vec, 8'h04);
        cyc();
        check("snoop_flush_pulse", snoop_flush, 0);
        snoop(6'b000000, 16'h0005);
        check("snoop_wr_no_flush", snoop_flush, 0);
        check("snoop_wr_state_i", state_vec, 8'h00);

        // upgrade lost to a snoop invalidate -> write miss
        issue(1'b0, 16'h0005, 16'h0000);
        cyc();
        grant();
        resp_valid = 1'b1; resp_data = 16'h2222; resp_shared = 1'b1;
        #1;
        check("refill_rdata", cpu_rdata, 16'h2222);
        cyc();
        resp_valid = 1'b0;
        #1;
        check("refill_state_s", state_vec, 8'h04);
        issue(1'b1, 16'h0005, 16'h7777);
        cyc();
        check("upg2_cmd", bus_cmd, 6'b000100);
        snoop(6'b000100, 16'h0005);
        check("upg2_snooped_inv", state_vec, 8'h00);
        check("upg2_req_dropped", bus_req, 0);
        cyc();
        check("upg2_fallback_req", bus_req, 1);
        check("upg2_fallback_cmd", bus_cmd, 6'b000000);
        check("upg2_fallback_addr", bus_addr, 16'h0005);
        grant();
        resp_valid = 1'b1; resp_data = 16'h0BAD;
        #1;
        check("upg2_fill_done", cpu_done, 1);
        cyc();
        resp_valid = 1'b0;
        #1;
        check("upg2_state_m", state_vec, 8'h08);
        issue(1'b0, 16'h0005, 16'h0000);
        check("upg2_rd_rdata", cpu_rdata, 16'h7777);
        cyc();

        // reset during WAIT_RESP
        issue(1'b0, 16'h0102, 16'h0000);
        cyc();
        grant();
        reset_n = 1'b0;
        #1;
        check("midrst_state_vec", state_vec, 8'h00);
        check("midrst_bus_req", bus_req, 0);
        cyc();
        reset_n = 1'b1;
        resp_valid = 1'b1; resp_data = 16'h1111;
        #1;
        check("late_resp_done", cpu_done, 0);
        check("late_resp_ready", cpu_ready, 1);
        cyc();
        resp_valid = 1'b0;
        #1;
        check("late_resp_state", state_vec, 8'h00);
        check("late_resp_bus_req", bus_req, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/coherence_line_controller.md
Name: coherence_line_controller

Overview:
- Parametrised successor to the single-line MSI snooping state machine.
- Owns a direct-mapped array of LINES cache lines, each holding a tag, data word and coherence state.
- Serves one CPU port through a valid/ready handshake and places coherence messages on the shared bus through a req/gnt handshake.
- Snoops other caches' bus messages, supports dirty-victim writeback, and optionally supports MESI (Exclusive state).

Parameters:
ADDR_W, 16, address width; index = addr[IDX_W-1:0], tag = addr[ADDR_W-1:IDX_W]
DATA_W, 16, data word width
LINES, 4, number of lines (power of 2, >=2); IDX_W = log2(LINES)
MESI, 0, 1 enables Exclusive state 2'b11; 0 gives pure MSI

Ports:
clock  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
cpu_valid  in  1  CPU request valid
cpu_ready  out  1  controller can accept a request
cpu_write  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  request address
cpu_wdata  in  DATA_W  write data
cpu_done  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  read data, valid with cpu_done
bus_req  out  1  request to emit on bus
bus_gnt  in  1  grant; emission occurs when bus_req&bus_gnt
bus_cmd  out  6  000000 write miss, 000001 read miss, 000100 invalidate, 000010 writeback
bus_addr  out  ADDR_W  emitted address
bus_data  out  DATA_W  emitted data (writeback only, else 0)
snoop_valid  in  1  foreign bus message valid
snoop_cmd  in  6  foreign command, same encoding as bus_cmd
snoop_addr  in  ADDR_W  foreign address
snoop_flush  out  1  one-cycle pulse: this cache supplies dirty data
snoop_flush_data  out  DATA_W  flushed data
resp_valid  in  1  fill response valid
resp_data  in  DATA_W  fill data
resp_shared  in  1  another cache holds the line
state_vec  out  2*LINES  line states, line i at [2i+1:2i]

Behaviour:
- State encoding: 00=I, 01=S, 10=M, 11=E (E only when MESI=1).
- Reset (async, reset_n=0):
  - All lines I; tags/data 0.
  - FSM to IDLE; pending request dropped.
  - All outputs 0 except cpu_ready=1 after reset release.
- FSM states: IDLE, LOOKUP, WB_REQ, MISS_REQ, UPG_REQ, WAIT_RESP.
- IDLE:
  - cpu_ready=1; accept on cpu_valid&cpu_ready and latch write/addr/wdata.
  - Go to LOOKUP.
  - cpu_ready=0 in all other states.
- LOOKUP (cycle after accept). Hit = tag match and state != I.
  - Read hit: cpu_done=1 and cpu_rdata=line data on this cycle; go to IDLE.
  - Write hit in M: write data, cpu_done; go to IDLE.
  - Write hit in E: state M, write data, cpu_done; no bus traffic.
  - Write hit in S: go to UPG_REQ.
  - Miss with victim in M: go to WB_REQ.
  - Miss otherwise: go to MISS_REQ.
- WB_REQ:
  - bus_req=1, cmd 000010, victim addr {victim tag, index}, victim data.
  - On grant: victim becomes I; go to MISS_REQ.
- MISS_REQ:
  - bus_req=1, cmd 000001 (read) or 000000 (write).
  - On grant: go to WAIT_RESP.
- UPG_REQ:
  - bus_req=1, cmd 000100.
  - On grant: line M, write data, cpu_done; go to IDLE.
  - If the line was snooped to I before grant: drop bus_req the next cycle and go to MISS_REQ (write miss).
- WAIT_RESP: on resp_valid, install tag, then:
  - Read: data=resp_data; state E if MESI & !resp_shared, else S; cpu_done with rdata=resp_data.
  - Write: data=cpu_wdata; state M; cpu_done.
  - Go to IDLE.
- Bus handshake:
  - bus_cmd/addr/data stable while bus_req=1 and not granted.
  - Emission completes in the req&gnt cycle.
  - bus_req deasserts the next cycle unless the next request state is entered.
- Snoop: evaluated every cycle, independent of FSM. Acts only on tag match with state != I.
  - read miss: M -> S with snoop_flush; E -> S; S unchanged.
  - write miss: M -> I with snoop_flush; E/S -> I.
  - invalidate: S/E -> I. (invalidate on M is not a legal bus condition; hold state.)
  - writeback and unknown commands: ignored.
  - snoop_flush and snoop_flush_data are registered: asserted the cycle after snoop_valid.
- Simultaneous events:
  - A snoop and a local update to the same line in one cycle: the snoop is applied first, then the local update.
  - Exceptions: fill install in WAIT_RESP, and UPG grant when the line is already S→I (handled by the UPG_REQ fallback above).
  - The controller never snoops its own emissions; the bus does not echo them.
- Index wrap: addresses differing only in tag map to the same line; a miss evicts the resident line.

Test Plan:
- Reset, then read addr 0x0005 (LINES=4) -> bus read miss (000001, 0x0005); resp_data=0xABCD, resp_shared=1 -> cpu_rdata=0xABCD, line1=S; with MESI=1 and resp_shared=0 -> line1=E.
- Line1 in S, write 0x0005 data 0x1234 -> cmd 000100 emitted; after grant, line1=M and cpu_done; read 0x0005 -> 0x1234 in LOOKUP cycle, no bus_req.
- Line1 M (0x0005=0x1234), read 0x0009 -> writeback 000010, addr 0x0005, data 0x1234; then read miss 0x0009; after resp, line1=S with new tag.
- Line1 M, snoop read miss 0x0005 -> snoop_flush=1, data 0x1234 next cycle, line1=S; snoop write miss 0x0005 -> I, no flush.
- Line1 S, write pending in UPG_REQ with bus_gnt=0; snoop invalidate 0x0005 -> line I; controller switches to cmd 000000, then completes via resp with line M.
- Assert reset_n=0 during WAIT_RESP -> state_vec=0, bus_req=0, cpu_ready=1 after release; late resp_valid ignored.
